// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bundle: two writeback requesters, the issue-side
// scoreboard update, and the register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               req0_valid;
  logic [RADDR_W-1:0] req0_rd;
  logic [XLEN-1:0]    req0_data;
  logic               req0_ready;
  logic               req1_valid;
  logic [RADDR_W-1:0] req1_rd;
  logic [XLEN-1:0]    req1_data;
  logic               req1_ready;
  logic               issue_valid;
  logic [RADDR_W-1:0] issue_rd;
  logic               wCtrl;
  logic [RADDR_W-1:0] wSel;
  logic [XLEN-1:0]    wData;
  logic [31:0]        busy;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output issue_valid, issue_rd,
    input  wCtrl, wSel, wData, busy
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  issue_valid, issue_rd,
    output wCtrl, wSel, wData, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter onto a single register-file write port,
// with a pending-write scoreboard.
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               wctrl_q, wctrl_d;
  logic [RADDR_W-1:0] wsel_q, wsel_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [31:0]        busy_q, busy_d;
  logic               gnt0, gnt1;

  // A lone requester wins in either state; contention follows the state.
  assign gnt0 = ~rst & bus.req0_valid
              & (~bus.req1_valid | (state_q == PRI0));
  assign gnt1 = ~rst & bus.req1_valid & ~gnt0;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign bus.wCtrl = wctrl_q;
  assign bus.wSel  = wsel_q;
  assign bus.wData = wdata_q;
  assign bus.busy  = busy_q;

  always_comb begin
    state_d = state_q;
    wctrl_d = 1'b0;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      gnt0: begin
        state_d = PRI1;
        wctrl_d = |bus.req0_rd;
        wsel_d  = bus.req0_rd;
        wdata_d = bus.req0_data;
      end
      gnt1: begin
        state_d = PRI0;
        wctrl_d = |bus.req1_rd;
        wsel_d  = bus.req1_rd;
        wdata_d = bus.req1_data;
      end
      default: ;
    endcase
  end

  // Set is applied after clear so a new in-flight write supersedes.
  always_comb begin
    busy_d = busy_q;
    if (wctrl_q)
      busy_d[wsel_q] = 1'b0;
    if (bus.issue_valid && (|bus.issue_rd))
      busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRI0;
      wctrl_q <= 1'b0;
      wsel_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      wctrl_q <= wctrl_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of the writeback data path.
REQ-002 Parameter RADDR_W, default 5: register-index width, giving 32 architectural registers.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req0_valid  input  1  ALU writeback request.
REQ-006 req0_rd  input  RADDR_W  destination register of the ALU writeback.
REQ-007 req0_data  input  XLEN  ALU writeback value.
REQ-008 req0_ready  output  1  ALU request is accepted this cycle.
REQ-009 req1_valid, req1_rd, req1_data, req1_ready  same directions and widths as the req0 ports  load-unit writeback request.
REQ-010 issue_valid  input  1  an instruction with a destination register issues this cycle.
REQ-011 issue_rd  input  RADDR_W  destination register of the issuing instruction.
REQ-012 wCtrl  output  1  register-file write enable.
REQ-013 wSel  output  RADDR_W  register-file write index.
REQ-014 wData  output  XLEN  register-file write data.
REQ-015 busy  output  32  per-register pending-write scoreboard; bit 0 is constant 0.

Function
REQ-016 The block shall arbitrate two writeback requesters onto the single register-file write port using a round-robin priority state machine with states PRI0 (req0 preferred) and PRI1 (req1 preferred).
REQ-017 Transaction: a request shall be accepted in any cycle where valid and ready are both high.
REQ-018 reqN_ready: combinational; high only for the single granted requester; never high for both in the same cycle.
REQ-019 Only one requester valid: it shall be granted regardless of state.
REQ-020 Both valid: the preferred requester shall be granted.
REQ-021 After any grant, the state shall move to prefer the non-granted requester (grant req0 -> PRI1, grant req1 -> PRI0).
REQ-022 No grant: the state shall be held.
REQ-023 Outputs wCtrl, wSel and wData shall be registered, giving fixed latency: a request accepted in cycle N drives the write port in cycle N+1.
REQ-024 The register file commits the value at the end of cycle N+1.
REQ-025 The output register shall drain every cycle; the arbiter never back-pressures because of the write port itself.
REQ-026 No acceptance in cycle N: wCtrl shall be 0 in N+1; wSel and wData hold their previous values.
REQ-027 Writes to rd=0 shall be accepted (ready high) and discarded: wCtrl stays 0 in N+1.
REQ-028 issue_valid with issue_rd!=0 shall set busy[issue_rd] from the next cycle.
REQ-029 issue_rd=0 shall have no effect on busy.
REQ-030 A write driven on the port (wCtrl=1 in cycle M) shall clear busy[wSel] from cycle M+1.
REQ-031 Set and clear of the same register in the same cycle: set wins, since the new in-flight write supersedes the old one.
REQ-032 Set and clear of different registers in the same cycle: both shall take effect.
REQ-033 busy shall be a pure register output with no combinational path from inputs.
REQ-034 An accepted request whose rd is not busy shall still be written; the scoreboard only tracks state and never blocks writeback.

Reset
REQ-035 While rst is high: req0_ready=0, req1_ready=0, and no request is accepted.
REQ-036 On the first clock edge with rst high: wCtrl=0, wSel=0, wData=0, busy=0, state=PRI0.
REQ-037 Reset asserted mid-operation shall discard any accepted-but-unwritten request: wCtrl=0 in the cycle after the reset edge, with no write to the register file.

Verification
REQ-038 Single requester: req0 valid, rd=5, data=0xDEADBEEF in cycle 1 -> req0_ready=1 in cycle 1; wCtrl=1, wSel=5, wData=0xDEADBEEF in cycle 2; wCtrl=0 in cycle 3.
REQ-039 Contention: both valid for 4 cycles from reset (rd0=1, rd1=2) -> grants req0, req1, req0, req1; wSel sequence 1, 2, 1, 2, each one cycle later.
REQ-040 x0 drop: req1 valid, rd=0, data=0x12345678 -> req1_ready=1; wCtrl=0 next cycle; busy stays 0.
REQ-041 Scoreboard: issue rd=7 in cycle 1 -> busy[7]=1 from cycle 2; req0 rd=7 accepted in cycle 3 -> wCtrl=1 in cycle 4; busy[7]=0 from cycle 5.
REQ-042 Simultaneous set/clear: issue rd=9 in the same cycle that wCtrl=1, wSel=9 -> busy[9]=1 next cycle.
REQ-043 Reset mid-flight: req0 accepted in cycle N, rst=1 in cycle N+1 -> wCtrl=0 in cycle N+2, busy=0, both ready=0 while rst is high, and state=PRI0 after reset releases.
